// File: rtl/vdp_port_ctrl_if.sv
// ----------------------------------------------------------------------------
// vdp_port_ctrl_if
//   CPU I/O-port bus and VRAM A-port bus of the VDP port controller.
//   slave  : controller side (vdp_port_ctrl)
//   master : CPU + VRAM side (bus owner / memory model)
//   cpu_wr/cpu_rd/cpu_port/cpu_din : CPU strobes, port select, write data
//   cpu_dout/cpu_wait              : read data (cycle after cpu_rd), busy
//   vram_addr/vram_din/vram_wr/vram_rd : VRAM A-port request
//   vram_dout                      : VRAM read data, 1-cycle synchronous
// ----------------------------------------------------------------------------
interface vdp_port_ctrl_if #(
    parameter int ADDR_W = 14
);
    logic              cpu_wr;
    logic              cpu_rd;
    logic              cpu_port;
    logic [7:0]        cpu_din;
    logic [7:0]        cpu_dout;
    logic              cpu_wait;
    logic [ADDR_W-1:0] vram_addr;
    logic [7:0]        vram_din;
    logic              vram_wr;
    logic              vram_rd;
    logic [7:0]        vram_dout;

    modport slave (
        input  cpu_wr, cpu_rd, cpu_port, cpu_din, vram_dout,
        output cpu_dout, cpu_wait, vram_addr, vram_din, vram_wr, vram_rd
    );

    modport master (
        output cpu_wr, cpu_rd, cpu_port, cpu_din, vram_dout,
        input  cpu_dout, cpu_wait, vram_addr, vram_din, vram_wr, vram_rd
    );
endinterface

// File: rtl/vdp_port_ctrl.sv
// ----------------------------------------------------------------------------
// vdp_port_ctrl
//   CPU-side controller of the TMS9918-style video block. Decodes the data
//   (cpu_port=0) and control (cpu_port=1) ports, runs the two-byte
//   address/register write protocol, sequences VRAM A-port writes and
//   read-ahead prefetches, holds R0..R7 and the status register, and
//   drives the video configuration outputs and n_int.
//
//   Ports:
//     clk, n_reset      : clock, asynchronous active-low reset
//     bus (slave)       : CPU port bus + VRAM A-port (see vdp_port_ctrl_if)
//     vblank, spr_coll, spr_5th, spr_5th_num : status set sources
//     mode .. back_color: decoded register fields for the video block
//     n_int             : active-low frame interrupt
//
//   Build option: VDP_REG_MASK_EN - when defined, register bits the video
//   block never decodes are stored as 0. Outputs are the same either way.
// ----------------------------------------------------------------------------
module vdp_port_ctrl #(
    parameter int ADDR_W   = 14,
    parameter int NUM_REGS = 8
) (
    input  logic        clk,
    input  logic        n_reset,
    vdp_port_ctrl_if.slave bus,
    input  logic        vblank,
    input  logic        spr_coll,
    input  logic        spr_5th,
    input  logic [4:0]  spr_5th_num,
    output logic [1:0]  mode,
    output logic        video_on,
    output logic        sprite_large,
    output logic        sprite_enlarged,
    output logic [13:0] name_table_addr,
    output logic [13:0] color_table_addr,
    output logic [13:0] font_addr,
    output logic [13:0] sprite_attr_addr,
    output logic [13:0] sprite_pattern_table_addr,
    output logic [3:0]  text_color,
    output logic [3:0]  back_color,
    output logic        n_int
);

    typedef enum logic [1:0] {
        PF_IDLE  = 2'd0,
        PF_ISSUE = 2'd1,
        PF_CAPT  = 2'd2,
        WR_CYC   = 2'd3
    } st_t;

    // Per-register keep masks, R7 first.
`ifdef VDP_REG_MASK_EN
    localparam logic [7:0][7:0] REG_KEEP = {8'hFF, 8'h07, 8'h7F, 8'h07,
                                            8'hFF, 8'h0F, 8'hFB, 8'h03};
`else
    localparam logic [7:0][7:0] REG_KEEP = {8{8'hFF}};
`endif

    st_t                      st, st_nxt;
    logic [NUM_REGS-1:0][7:0] regs;
    logic [ADDR_W-1:0]        addr;
    logic [7:0]               rd_buf;
    logic [7:0]               latch;
    logic [7:0]               wdata;
    logic                     flag;
    logic [7:0]               dout_q;
    logic                     st_f, st_5s, st_c;
    logic [4:0]               fifth_num;

    logic acc_wr, acc_rd;
    logic do_data_wr, do_ctrl_wr, do_data_rd, do_stat_rd;
    logic start_pf;
    logic vram_wr_c, vram_rd_c;

    // ------------------------------------------------------------------
    // Access decode + sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) st <= PF_IDLE;
        else          st <= st_nxt;
    end

    always_comb begin
        st_nxt    = st;
        vram_wr_c = 1'b0;
        vram_rd_c = 1'b0;
        acc_wr    = 1'b0;
        acc_rd    = 1'b0;
        // strobes only land while idle; wr+rd together counts as a write
        if (st == PF_IDLE) begin
            acc_wr = bus.cpu_wr;
            acc_rd = bus.cpu_rd & ~bus.cpu_wr;
        end
        do_data_wr = acc_wr & ~bus.cpu_port;
        do_ctrl_wr = acc_wr &  bus.cpu_port;
        do_data_rd = acc_rd & ~bus.cpu_port;
        do_stat_rd = acc_rd &  bus.cpu_port;
        start_pf   = do_data_rd |
                     (do_ctrl_wr & flag & (bus.cpu_din[7:6] == 2'b00));
        unique case (st)
            PF_IDLE: begin
                if (do_data_wr)    st_nxt = WR_CYC;
                else if (start_pf) st_nxt = PF_ISSUE;
            end
            PF_ISSUE: begin
                vram_rd_c = 1'b1;
                st_nxt    = PF_CAPT;
            end
            PF_CAPT: st_nxt = PF_IDLE;
            WR_CYC: begin
                vram_wr_c = 1'b1;
                st_nxt    = PF_IDLE;
            end
            default: st_nxt = PF_IDLE;
        endcase
    end

    assign bus.cpu_wait  = (st != PF_IDLE);
    assign bus.vram_wr   = vram_wr_c;
    assign bus.vram_rd   = vram_rd_c;
    assign bus.vram_addr = addr;
    assign bus.vram_din  = wdata;
    assign bus.cpu_dout  = dout_q;

    // ------------------------------------------------------------------
    // Port datapath: latch/flag, registers, pointer, read buffer
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            regs   <= '0;
            addr   <= '0;
            rd_buf <= '0;
            latch  <= '0;
            wdata  <= '0;
            flag   <= 1'b0;
            dout_q <= '0;
        end else begin
            if (do_ctrl_wr) begin
                if (!flag) begin
                    latch <= bus.cpu_din;
                    flag  <= 1'b1;
                end else begin
                    flag <= 1'b0;
                    if (bus.cpu_din[7])
                        regs[bus.cpu_din[2:0]] <= latch & REG_KEEP[bus.cpu_din[2:0]];
                    else
                        addr <= ADDR_W'({bus.cpu_din[5:0], latch});
                end
            end
            // data is captured at the strobe; the VRAM write happens next cycle
            if (do_data_wr) begin
                wdata <= bus.cpu_din;
                flag  <= 1'b0;
            end
            if (st == WR_CYC) begin
                rd_buf <= wdata;
                addr   <= addr + ADDR_W'(1);
            end
            if (st == PF_CAPT) begin
                rd_buf <= bus.vram_dout;
                addr   <= addr + ADDR_W'(1);
            end
            if (do_data_rd) begin
                dout_q <= rd_buf;
                flag   <= 1'b0;
            end
            if (do_stat_rd) begin
                dout_q <= {st_f, st_5s, st_c, fifth_num};
                flag   <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Status register. A set pulse wins over a coinciding status-read
    // clear; the read itself still returns the pre-set value.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            st_f      <= 1'b0;
            st_5s     <= 1'b0;
            st_c      <= 1'b0;
            fifth_num <= '0;
        end else begin
            st_f  <= vblank   | (st_f  & ~do_stat_rd);
            st_c  <= spr_coll | (st_c  & ~do_stat_rd);
            st_5s <= spr_5th  | (st_5s & ~do_stat_rd);
            // number is frozen while 5S is held; a read frees it again
            if (spr_5th && (!st_5s || do_stat_rd))
                fifth_num <= spr_5th_num;
            else if (do_stat_rd)
                fifth_num <= '0;
        end
    end

    // ------------------------------------------------------------------
    // Decoded configuration
    // ------------------------------------------------------------------
    always_comb begin
        if (regs[1][4])      mode = 2'd0;
        else if (regs[0][1]) mode = 2'd2;
        else                 mode = 2'd1;
    end

    assign video_on                  = regs[1][6];
    assign sprite_large              = regs[1][1];
    assign sprite_enlarged           = regs[1][0];
    assign name_table_addr           = {regs[2][3:0], 10'b0};
    assign color_table_addr          = {regs[3], 6'b0};
    assign font_addr                 = {regs[4][2:0], 11'b0};
    assign sprite_attr_addr          = {regs[5][6:0], 7'b0};
    assign sprite_pattern_table_addr = {regs[6][2:0], 11'b0};
    assign text_color                = regs[7][7:4];
    assign back_color                = regs[7][3:0];
    assign n_int                     = ~(st_f & regs[1][5]);

    // register bits the video block never looks at
    logic unused_reg_bits;
    assign unused_reg_bits = ^{regs[0][7:2], regs[0][0], regs[1][7], regs[1][3:2],
                               regs[2][7:4], regs[4][7:3], regs[5][7], regs[6][7:3]};

endmodule

// File: tb/tb_vdp_port_ctrl.sv
module tb_vdp_port_ctrl;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        vblank = 1'b0, spr_coll = 1'b0, spr_5th = 1'b0;
    logic [4:0]  spr_5th_num = '0;
    logic [1:0]  mode;
    logic        video_on, sprite_large, sprite_enlarged, n_int;
    logic [13:0] name_table_addr, color_table_addr, font_addr;
    logic [13:0] sprite_attr_addr, sprite_pattern_table_addr;
    logic [3:0]  text_color, back_color;

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_rd[$];
    logic [21:0] exp_wr[$];
    logic [7:0]  mem [0:16383];

    vdp_port_ctrl_if #(.ADDR_W(14)) bus ();

    vdp_port_ctrl #(.ADDR_W(14), .NUM_REGS(8)) dut (
        .clk(clk), .n_reset(n_reset), .bus(bus.slave),
        .vblank(vblank), .spr_coll(spr_coll), .spr_5th(spr_5th), .spr_5th_num(spr_5th_num),
        .mode(mode), .video_on(video_on), .sprite_large(sprite_large),
        .sprite_enlarged(sprite_enlarged), .name_table_addr(name_table_addr),
        .color_table_addr(color_table_addr), .font_addr(font_addr),
        .sprite_attr_addr(sprite_attr_addr),
        .sprite_pattern_table_addr(sprite_pattern_table_addr),
        .text_color(text_color), .back_color(back_color), .n_int(n_int)
    );

    always #5 clk = ~clk;

    // VRAM A-port model, 1-cycle synchronous read
    always @(posedge clk) begin
        if (bus.vram_wr) mem[bus.vram_addr] = bus.vram_din;
        if (bus.vram_rd) bus.vram_dout <= mem[bus.vram_addr];
    end

    // read-data monitor: an accepted read presents cpu_dout the next cycle
    always @(posedge clk) begin
        if (n_reset && bus.cpu_rd && !bus.cpu_wr && !bus.cpu_wait) begin
            @(negedge clk);
            checks++;
            if (exp_rd.size() == 0) begin
                errors++;
                $display("FAIL rd_data: got %02h, no read was expected", bus.cpu_dout);
            end else begin
                logic [7:0] e;
                e = exp_rd.pop_front();
                if (bus.cpu_dout !== e) begin
                    errors++;
                    $display("FAIL rd_data: got %02h expected %02h", bus.cpu_dout, e);
                end
            end
        end
    end

    // VRAM write monitor
    always @(negedge clk) begin
        if (bus.vram_wr) begin
            checks++;
            if (exp_wr.size() == 0) begin
                errors++;
                $display("FAIL vram_wr: unexpected write %04h=%02h", bus.vram_addr, bus.vram_din);
            end else begin
                logic [21:0] e;
                e = exp_wr.pop_front();
                if ({bus.vram_addr, bus.vram_din} !== e || bus.vram_rd) begin
                    errors++;
                    $display("FAIL vram_wr: got %04h=%02h rd=%0b expected %04h=%02h rd=0",
                             bus.vram_addr, bus.vram_din, bus.vram_rd, e[21:8], e[7:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %04h expected %04h", name, got, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (bus.cpu_wait && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 50) begin
            checks++; errors++;
            $display("FAIL wait_idle: cpu_wait stuck high");
        end
    endtask

    // returns #1 after the accepting edge
    task automatic strobe(input logic wr, input logic port, input logic [7:0] d);
        wait_idle();
        bus.cpu_wr = wr; bus.cpu_rd = ~wr; bus.cpu_port = port; bus.cpu_din = d;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
    endtask

    task automatic ctrl2(input logic [7:0] b0, input logic [7:0] b1);
        strobe(1'b1, 1'b1, b0);
        strobe(1'b1, 1'b1, b1);
    endtask

    task automatic rd(input logic port, input logic [7:0] e);
        wait_idle();
        exp_rd.push_back(e);
        strobe(1'b0, port, 8'h00);
    endtask

    task automatic count_wait(input string name, input int e);
        int n = 0;
        while (bus.cpu_wait && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check(name, 16'(n), 16'(e));
    endtask

    task automatic pulse(input int which, input logic [4:0] num);
        if (which == 0) vblank = 1'b1;
        if (which == 1) spr_coll = 1'b1;
        if (which == 2) begin spr_5th = 1'b1; spr_5th_num = num; end
        @(posedge clk); #1;
        vblank = 1'b0; spr_coll = 1'b0; spr_5th = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 8'h00;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0; bus.cpu_port = 1'b0; bus.cpu_din = 8'h00;
        bus.vram_dout = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check("rst_n_int", 16'(n_int), 16'd1);
        check("rst_wait", 16'(bus.cpu_wait), 16'd0);
        check("rst_strobes", {14'd0, bus.vram_wr, bus.vram_rd}, 16'd0);
        n_reset = 1'b1;
        @(posedge clk); #1;
        check("rst_dout", 16'(bus.cpu_dout), 16'h00);
        check("rst_mode", 16'(mode), 16'd1);
        check("rst_name", 16'(name_table_addr), 16'h0000);

        // register write
        ctrl2(8'h02, 8'h82);
        check("reg_name_tbl", 16'(name_table_addr), 16'h0800);

        // write setup + data writes (flag must be clear after the register write)
        ctrl2(8'h00, 8'h40);
        check("setup_nowait", 16'(bus.cpu_wait), 16'd0);
        exp_wr.push_back({14'h0000, 8'hAA});
        strobe(1'b1, 1'b0, 8'hAA);
        count_wait("wr_wait0", 1);
        exp_wr.push_back({14'h0001, 8'h55});
        strobe(1'b1, 1'b0, 8'h55);
        count_wait("wr_wait1", 1);
        check("vram0", 16'(mem[0]), 16'h00AA);
        check("vram1", 16'(mem[1]), 16'h0055);
        rd(1'b0, 8'h55);          // buffer holds last written byte
        count_wait("rd_wait", 2);
        rd(1'b0, 8'h00);          // prefetched from addr 2

        // read-ahead with wrap
        mem[14'h3FFF] = 8'h12;
        mem[0] = 8'h34;
        strobe(1'b1, 1'b1, 8'hFF);
        strobe(1'b1, 1'b1, 8'h3F);
        count_wait("pf_wait", 2);
        rd(1'b0, 8'h12);
        count_wait("pf_wait2", 2);
        rd(1'b0, 8'h34);

        // interrupt
        ctrl2(8'h20, 8'h81);
        check("int_idle", 16'(n_int), 16'd1);
        pulse(0, 5'd0);
        check("int_set", 16'(n_int), 16'd0);
        rd(1'b1, 8'h80);
        check("int_clr", 16'(n_int), 16'd1);
        rd(1'b1, 8'h00);

        // status read coinciding with vblank: old value read, F ends up set
        wait_idle();
        exp_rd.push_back(8'h00);
        vblank = 1'b1;
        bus.cpu_rd = 1'b1; bus.cpu_port = 1'b1;
        @(posedge clk); #1;
        bus.cpu_rd = 1'b0; vblank = 1'b0;
        check("coin_int", 16'(n_int), 16'd0);
        rd(1'b1, 8'h80);

        // collision and fifth sprite
        pulse(1, 5'd0);
        rd(1'b1, 8'h20);
        pulse(2, 5'd3);
        pulse(2, 5'd7);
        rd(1'b1, 8'h43);
        rd(1'b1, 8'h00);

        // flag reset by status read
        strobe(1'b1, 1'b1, 8'h10);
        rd(1'b1, 8'h00);
        ctrl2(8'h05, 8'h87);
        check("flag_r7", {8'h00, text_color, back_color}, 16'h0005);

        // configuration decode
        ctrl2(8'h02, 8'h80);
        check("mode_g2", 16'(mode), 16'd2);
        ctrl2(8'h53, 8'h81);
        check("mode_txt", 16'(mode), 16'd0);
        check("r1_bits", {13'd0, video_on, sprite_large, sprite_enlarged}, 16'h0007);
        ctrl2(8'hFF, 8'h83);
        check("color_tbl", 16'(color_table_addr), 16'h3FC0);
        ctrl2(8'h07, 8'h84);
        check("font", 16'(font_addr), 16'h3800);
        ctrl2(8'hFF, 8'h85);
        check("spr_attr", 16'(sprite_attr_addr), 16'h3F80);
        ctrl2(8'h07, 8'h86);
        check("spr_pat", 16'(sprite_pattern_table_addr), 16'h3800);

        // strobe during wait ignored; wr+rd together acts as a write
        ctrl2(8'h00, 8'h41);
        exp_wr.push_back({14'h0100, 8'h77});
        strobe(1'b1, 1'b0, 8'h77);
        bus.cpu_wr = 1'b1; bus.cpu_port = 1'b0; bus.cpu_din = 8'h99;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0;
        wait_idle();
        exp_wr.push_back({14'h0101, 8'h5A});
        bus.cpu_wr = 1'b1; bus.cpu_rd = 1'b1; bus.cpu_port = 1'b0; bus.cpu_din = 8'h5A;
        @(posedge clk); #1;
        bus.cpu_wr = 1'b0; bus.cpu_rd = 1'b0;
        wait_idle();
        check("ign_100", 16'(mem[14'h0100]), 16'h0077);
        check("ign_101", 16'(mem[14'h0101]), 16'h005A);
        check("ign_102", 16'(mem[14'h0102]), 16'h0000);

        // reset mid-prefetch
        ctrl2(8'h00, 8'h00);
        check("pf_busy", 16'(bus.cpu_wait), 16'd1);
        n_reset = 1'b0;
        #1;
        check("mid_rst_wait", 16'(bus.cpu_wait), 16'd0);
        check("mid_rst_rd", 16'(bus.vram_rd), 16'd0);
        @(posedge clk); #1;
        n_reset = 1'b1;
        @(posedge clk); #1;
        check("mid_rst_name", 16'(name_table_addr), 16'h0000);
        rd(1'b0, 8'h00);          // buffer was cleared, not 0x34
        wait_idle();
        repeat (2) @(posedge clk);
        #1;

        check("rd_queue_empty", 16'(exp_rd.size()), 16'd0);
        check("wr_queue_empty", 16'(exp_wr.size()), 16'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

endmodule

// File: doc/vdp_port_ctrl.md
Name: vdp_port_ctrl

Overview:
CPU-side controller for the TMS9918-style video block. It decodes the two VDP I/O ports (data and control) and sequences every CPU access to the shared VRAM port, including the two-byte address/register write protocol, address auto-increment and the read-ahead buffer. It holds registers R0-R7 and drives the video block's configuration inputs. It also owns the status register and the frame interrupt. It runs in the cpu_clk domain, which is the same clock as the VRAM A port.

Parameters:
ADDR_W, 14, VRAM address width
NUM_REGS, 8, number of control registers (R0..R7)

Ports:
clk  in  1  CPU/VRAM-A clock
n_reset  in  1  asynchronous active-low reset
cpu_wr  in  1  one-cycle write strobe
cpu_rd  in  1  one-cycle read strobe
cpu_port  in  1  0 = data port (0x98), 1 = control port (0x99)
cpu_din  in  8  CPU write data
cpu_dout  out  8  CPU read data, valid in the cycle after cpu_rd
cpu_wait  out  1  controller busy; strobes are not accepted while high
vram_addr  out  14  VRAM A-port address
vram_din  out  8  VRAM write data
vram_wr  out  1  VRAM write enable
vram_rd  out  1  VRAM read enable
vram_dout  in  8  VRAM read data, 1-cycle synchronous
vblank  in  1  one-cycle frame-end pulse from the video block
spr_coll  in  1  sprite collision pulse
spr_5th  in  1  fifth-sprite pulse
spr_5th_num  in  5  sprite number that accompanies spr_5th
mode  out  2  0 = text (R1.4), 2 = graphics II (R0.1), otherwise 1
video_on  out  1  R1.6
sprite_large  out  1  R1.1
sprite_enlarged  out  1  R1.0
name_table_addr  out  14  {R2[3:0], 10'b0}
color_table_addr  out  14  {R3, 6'b0}
font_addr  out  14  {R4[2:0], 11'b0}
sprite_attr_addr  out  14  {R5[6:0], 7'b0}
sprite_pattern_table_addr  out  14  {R6[2:0], 11'b0}
text_color  out  4  R7[7:4]
back_color  out  4  R7[3:0]
n_int  out  1  ~(F & R1.5)

Behaviour:
- Reset (async, n_reset low):
  - R0-R7, address pointer, read buffer, latch byte and status = 0.
  - first-byte flag cleared.
  - All strobes low; cpu_wait = 0; cpu_dout = 0; n_int = 1.
- Control write, flag clear: latch <= cpu_din; flag set.
- Control write, flag set; flag is cleared in every case:
  - cpu_din[7] = 1: R[cpu_din[2:0]] <= latch.
  - cpu_din[7:6] = 01: addr <= {cpu_din[5:0], latch}. Write setup only, no VRAM access.
  - cpu_din[7:6] = 00: addr <= {cpu_din[5:0], latch}, then a prefetch is started.
- Prefetch sequence: PF_IDLE -> PF_ISSUE -> PF_CAPT -> PF_IDLE.
  - PF_ISSUE: vram_rd = 1, vram_addr = addr.
  - PF_CAPT: buffer <= vram_dout; addr <= addr + 1.
  - cpu_wait is high during PF_ISSUE and PF_CAPT. The prefetch costs 2 cycles after the triggering strobe.
- Data write (one cycle after the strobe):
  - vram_wr = 1, vram_addr = addr, vram_din = cpu_din.
  - buffer <= cpu_din; addr <= addr + 1; flag cleared.
  - cpu_wait is high for that 1 cycle.
- Data read:
  - cpu_dout <= buffer, valid in the next cycle.
  - A prefetch is then started at the current addr; flag cleared.
- Status read:
  - cpu_dout <= {F, 5S, C, fifth_num[4:0]}.
  - F, 5S and C are cleared in the same cycle; flag cleared.
- Status set sources:
  - vblank sets F.
  - spr_coll sets C.
  - spr_5th sets 5S and latches spr_5th_num, but only if 5S is currently 0. While 5S is set, fifth_num is held.
- Status read coinciding with a set pulse: the read returns the pre-set value, and the set takes precedence, so the flag is 1 afterwards.
- Address wrap: 0x3FFF + 1 = 0x0000.
- Strobes while cpu_wait = 1 are ignored. They have no side effects, and the flag is unchanged.
- cpu_wr and cpu_rd asserted together: treated as a write.
- vram_wr and vram_rd are never high in the same cycle.
- Reset mid-prefetch: state returns to PF_IDLE and the buffer is cleared.

Optional Feature:
VDP_REG_MASK_EN: when defined, unused register bits are stored as 0:
- R0 keeps [1:0].
- R1 keeps [7:0] minus bit 2.
- R2 keeps [3:0].
- R4 keeps [2:0].
- R5 keeps [6:0].
- R6 keeps [2:0].
When the macro is undefined, all 8 bits of every register are stored. Outputs are identical in both cases because only the decoded bits are used.

Test Plan:
- Register write: ctrl 0x02, ctrl 0x82 -> R2 = 0x02, name_table_addr = 0x0800; flag clear afterwards.
- Write setup and data: ctrl 0x00, ctrl 0x40, data 0xAA, data 0x55 -> VRAM[0] = 0xAA, VRAM[1] = 0x55, addr = 2; each write causes 1 wait cycle.
- Read-ahead: preload VRAM[0x3FFF] = 0x12 and VRAM[0] = 0x34; ctrl 0xFF, ctrl 0x3F -> 2 wait cycles; data read returns 0x12, next data read returns 0x34 (wrap).
- Interrupt: R1 = 0x20, pulse vblank -> n_int = 0; status read returns bit7 = 1, then n_int = 1; a second status read returns bit7 = 0.
- Fifth sprite: spr_5th with num 3, then spr_5th with num 7 -> status = 0x43; after the read, status = 0x00.
- Flag reset: ctrl 0x10, then status read, then ctrl 0x05, ctrl 0x87 -> R7 = 0x05, not 0x10.
